// File: rtl/adc_word_packer.sv
// Packs pairs of kept (optionally decimated) ADC samples into tagged 32-bit words for the FIFO-to-SPI stage.
// Optional feature macro PACKER_PARITY_EN: bit 31 becomes even parity over [30:0] and the tag narrows to 3 bits.
module adc_word_packer #(
    parameter int          SAMPLE_W = 12,
    parameter int          DECIM    = 1,
    parameter logic [13:0] PAD      = 14'h3FFF
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                flush,
    output logic                we,
    output logic [31:0]         dout,
    output logic                busy
);

    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef PACKER_PARITY_EN
    localparam int TAG_W = 3;
`else
    localparam int TAG_W = 4;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALF = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [TAG_W-1:0]  wtag_q, wtag_d;
    logic [13:0]       slot_a_q, slot_a_d;
    logic [31:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              kept_s;
    logic [13:0]       sample_s;

    function automatic logic [31:0] build_word(input logic [TAG_W-1:0] tag,
                                               input logic [13:0] a,
                                               input logic [13:0] b);
        logic [31:0] word;
`ifdef PACKER_PARITY_EN
        word = {1'b0, tag, a, b};
        word[31] = ^word[30:0];
`else
        word = {tag, a, b};
`endif
        return word;
    endfunction

    assign sample_s = 14'(s_data);
    assign kept_s   = en & s_valid & (dcnt_q == '0);

    // Next-state logic: decimation counter, pairing FSM, word assembly.
    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        wtag_d   = wtag_q;
        slot_a_d = slot_a_q;
        dout_d   = dout_q;

        if (!en) begin
            dcnt_d = '0;
        end else if (s_valid) begin
            if (dcnt_q == DCNT_W'(DECIM - 1)) begin
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end
        end else begin
            dcnt_d = dcnt_q;
        end

        // The tag advances after every emitted word, even if en drops meanwhile.
        if (state_q == ST_EMIT) begin
            wtag_d = wtag_q + TAG_W'(1);
        end else begin
            wtag_d = wtag_q;
        end

        if (!en) begin
            state_d  = ST_IDLE;
            slot_a_d = 14'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (kept_s && flush) begin
                        dout_d  = build_word(wtag_q, sample_s, PAD);
                        state_d = ST_EMIT;
                    end else if (kept_s) begin
                        slot_a_d = sample_s;
                        state_d  = ST_HALF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HALF: begin
                    if (kept_s) begin
                        dout_d  = build_word(wtag_q, slot_a_q, sample_s);
                        state_d = ST_EMIT;
                    end else if (flush) begin
                        dout_d  = build_word(wtag_q, slot_a_q, PAD);
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_HALF;
                    end
                end
                ST_EMIT: begin
                    if (kept_s) begin
                        slot_a_d = sample_s;
                        state_d  = ST_HALF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    slot_a_d = 14'h0000;
                end
            endcase
        end

        we_d   = (state_d == ST_EMIT);
        busy_d = (state_d == ST_HALF);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            dcnt_q   <= '0;
            wtag_q   <= '0;
            slot_a_q <= 14'h0000;
            dout_q   <= 32'h0000_0000;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            wtag_q   <= wtag_d;
            slot_a_q <= slot_a_d;
            dout_q   <= dout_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
        end
    end

    assign we   = we_q;
    assign dout = dout_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_adc_word_packer.sv
// Directed self-checking bench for adc_word_packer (default and DECIM=3 instances).
module tb_adc_word_packer;

    logic        clk = 1'b0;
    logic        nrst, en, s_valid, flush;
    logic [11:0] s_data;
    logic        we, busy, we3, busy3;
    logic [31:0] dout, dout3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] wq[$];
    int          wc[$];
    logic [31:0] wq3[$];

    adc_word_packer #(.SAMPLE_W(12), .DECIM(1)) u_dut (
        .clk(clk), .nrst(nrst), .en(en), .s_valid(s_valid), .s_data(s_data),
        .flush(flush), .we(we), .dout(dout), .busy(busy)
    );

    adc_word_packer #(.SAMPLE_W(12), .DECIM(3)) u_dec (
        .clk(clk), .nrst(nrst), .en(en), .s_valid(s_valid), .s_data(s_data),
        .flush(flush), .we(we3), .dout(dout3), .busy(busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            wq.push_back(dout);
            wc.push_back(cyc);
        end
        if (we3) wq3.push_back(dout3);
    end

    // Apply the parity bit when the parity build is selected; w holds a hand-built word with bit 31 clear.
    function automatic logic [31:0] pw(input logic [31:0] w);
`ifdef PACKER_PARITY_EN
        return {^w[30:0], w[30:0]};
`else
        return w;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [11:0] d, input logic f);
        s_valid = v;
        s_data  = d;
        flush   = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 12'h000; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we", {31'd0, we}, 32'd0);
        check_eq("rst_dout", dout, 32'h0000_0000);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        nrst = 1'b1;
        en   = 1'b1;
        wq.delete();
        wc.delete();
        wq3.delete();
    endtask

    initial begin
        logic [31:0] w;
        int          nw;

        // Basic pair
        do_reset();
        step(1'b1, 12'h123, 1'b0);
        check_eq("pair_busy_half", {31'd0, busy}, 32'd1);
        step(1'b1, 12'h456, 1'b0);
        check_eq("pair_we", {31'd0, we}, 32'd1);
        step(1'b0, 12'h000, 1'b0);
        check_eq("pair_we_drop", {31'd0, we}, 32'd0);
        step(1'b0, 12'h000, 1'b0);
        check_eq("pair_count", wq.size(), 32'd1);
        if (wq.size() > 0) check_eq("pair_word", wq[0], pw(32'h0048_C456));
        check_eq("pair_busy_end", {31'd0, busy}, 32'd0);
        check_eq("pair_dout_hold", dout, pw(32'h0048_C456));

        // 34 back-to-back samples
        do_reset();
        for (int k = 0; k < 34; k++) step(1'b1, 12'(k + 1), 1'b0);
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        check_eq("b2b_count", wq.size(), 32'd17);
        nw = (wq.size() < 17) ? wq.size() : 17;
        for (int k = 0; k < nw; k++) begin
`ifdef PACKER_PARITY_EN
            w = (32'(k % 8) << 28) | (32'(2 * k + 1) << 14) | 32'(2 * k + 2);
`else
            w = (32'(k % 16) << 28) | (32'(2 * k + 1) << 14) | 32'(2 * k + 2);
`endif
            check_eq($sformatf("b2b_word%0d", k), wq[k], pw(w));
            if (k > 0) check_eq($sformatf("b2b_gap%0d", k), 32'(wc[k] - wc[k-1]), 32'd2);
        end

        // Decimation by 3 on the second instance
        do_reset();
        for (int k = 1; k <= 12; k++) step(1'b1, 12'(k), 1'b0);
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        check_eq("dec_count", wq3.size(), 32'd2);
        if (wq3.size() > 0) check_eq("dec_word0", wq3[0], pw(32'h0000_4004));
        if (wq3.size() > 1) check_eq("dec_word1", wq3[1], pw(32'h1001_C00A));

        // Flush of a half word, then a flush while idle
        do_reset();
        step(1'b1, 12'h0AB, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b1);
        check_eq("flush_we_latency", {31'd0, we}, 32'd1);
        check_eq("flush_dout", dout, pw(32'h002A_FFFF));
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b1);
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        check_eq("flush_idle_count", wq.size(), 32'd1);
        // Flush together with a kept sample in IDLE
        step(1'b1, 12'h005, 1'b1);
        check_eq("flush_idle_kept_we", {31'd0, we}, 32'd1);
        check_eq("flush_idle_kept_dout", dout, pw(32'h1001_7FFF));
        step(1'b0, 12'h000, 1'b0);
        check_eq("flush_idle_kept_busy", {31'd0, busy}, 32'd0);
        // Flush together with a kept sample in HALF: sample wins slot B
        step(1'b1, 12'h001, 1'b0);
        step(1'b1, 12'h002, 1'b1);
        step(1'b0, 12'h000, 1'b0);
        check_eq("flush_half_kept_count", wq.size(), 32'd3);
        if (wq.size() > 2) check_eq("flush_half_kept_word", wq[2], pw(32'h2000_4002));

        // en low discards slot A
        do_reset();
        step(1'b1, 12'h0AB, 1'b0);
        en = 1'b0;
        step(1'b0, 12'h000, 1'b0);
        check_eq("en_low_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        step(1'b1, 12'h001, 1'b0);
        step(1'b1, 12'h002, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        check_eq("en_low_count", wq.size(), 32'd1);
        if (wq.size() > 0) check_eq("en_low_word", wq[0], pw(32'h0000_4002));

        // Pair, then asynchronous reset while HALF
        do_reset();
        step(1'b1, 12'h001, 1'b0);
        step(1'b1, 12'h000, 1'b0);
        check_eq("par_dout", dout, pw(32'h0000_4000));
`ifdef PACKER_PARITY_EN
        check_eq("par_dout_abs", dout, 32'h8000_4000);
`endif
        step(1'b1, 12'h007, 1'b0);
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        s_valid = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        check_eq("mid_rst_we", {31'd0, we}, 32'd0);
        check_eq("mid_rst_dout", dout, 32'h0000_0000);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        step(1'b0, 12'h000, 1'b1);
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        check_eq("mid_rst_count", wq.size(), 32'd1);
        check_eq("mid_rst_dout_after", dout, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
